// File: rtl/usr_pkg.sv
// rtl/usr_pkg.sv - mode constants and FSM state encoding for the universal shift register
package usr_pkg;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SHR  = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_LOAD = 3'b011;
  localparam logic [2:0] MODE_ROR  = 3'b100;
  localparam logic [2:0] MODE_ROL  = 3'b101;
  localparam logic [2:0] MODE_ASR  = 3'b110;
  localparam logic [2:0] MODE_RSVD = 3'b111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } usr_state_e;

endpackage

// File: rtl/usr_next.sv
// rtl/usr_next.sv - combinational next-value function of the shift register
module usr_next
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] cur,
  input  logic [2:0]       mode,
  input  logic             ser_in_r,
  input  logic             ser_in_l,
  input  logic [WIDTH-1:0] par_in,
  output logic [WIDTH-1:0] nxt
);

  // Select the value one step of the given mode produces from cur
  always_comb begin
    nxt = cur;
    case (mode)
      MODE_SHR:  nxt = {ser_in_r, cur[WIDTH-1:1]};
      MODE_SHL:  nxt = {cur[WIDTH-2:0], ser_in_l};
      MODE_LOAD: nxt = par_in;
      MODE_ROR:  nxt = {cur[0], cur[WIDTH-1:1]};
      MODE_ROL:  nxt = {cur[WIDTH-2:0], cur[WIDTH-1]};
      MODE_ASR:  nxt = {cur[WIDTH-1], cur[WIDTH-1:1]};
      default:   nxt = cur;  // HOLD and the reserved code
    endcase
  end

endmodule

// File: rtl/usr_n.sv
// rtl/usr_n.sv - parametrised universal shift register with counted burst mode
module usr_n
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             ser_in_r,
  input  logic             ser_in_l,
  input  logic [WIDTH-1:0] par_in,
  input  logic             start,
  input  logic [CW-1:0]    shamt,
  output logic [WIDTH-1:0] out,
  output logic             ser_out_r,
  output logic             ser_out_l,
  output logic             busy,
  output logic             done
);

  usr_state_e       state_q;
  logic [2:0]       m_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] out_q;
  logic             busy_q;
  logic             done_q;
  logic [2:0]       mode_sel;
  logic [WIDTH-1:0] out_d;

  // A burst steps with the mode latched at start; single steps use the live mode
  always_comb begin
    mode_sel = (state_q == ST_RUN) ? m_q : mode;
  end

  usr_next #(
    .WIDTH(WIDTH)
  ) u_next (
    .cur      (out_q),
    .mode     (mode_sel),
    .ser_in_r (ser_in_r),
    .ser_in_l (ser_in_l),
    .par_in   (par_in),
    .nxt      (out_d)
  );

  // Burst FSM, step counter, handshake flags and the shift register itself
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      m_q     <= MODE_HOLD;
      cnt_q   <= '0;
      out_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            // Accepting a burst does not move out; steps begin next edge
            m_q   <= mode;
            cnt_q <= shamt;
            if (shamt != '0) begin
              state_q <= ST_RUN;
              busy_q  <= 1'b1;
            end else begin
              done_q <= 1'b1;
            end
          end else if (en) begin
            out_q <= out_d;
          end
        end
        ST_RUN: begin
          out_q <= out_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign out       = out_q;
  assign ser_out_r = out_q[0];
  assign ser_out_l = out_q[WIDTH-1];
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
